// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and saturating arithmetic for the SNN core.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int c_MAX_W = 32;

    // Operands are zero-extended to c_MAX_W; the result is clamped to 2^w-1.
    function automatic logic [c_MAX_W-1:0] sat_add(input logic [c_MAX_W-1:0] a,
                                                   input logic [c_MAX_W-1:0] b,
                                                   input int unsigned        w);
        logic [c_MAX_W:0] sum;
        logic [c_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((c_MAX_W+1)'(1) << w) - (c_MAX_W+1)'(1);
        return (sum > lim) ? lim[c_MAX_W-1:0] : sum[c_MAX_W-1:0];
    endfunction

    function automatic logic [c_MAX_W-1:0] sat_sub(input logic [c_MAX_W-1:0] a,
                                                   input logic [c_MAX_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array_if
// Description : Event-in, tick and spike-out handshakes of the neuron array.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_array_if #(
    parameter int IDX_W = 3
);
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_ready;
    logic             tick;
    logic             tick_ready;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_idx;
    logic             spike_ready;

    modport master (
        output evt_valid, evt_idx, tick, spike_ready,
        input  evt_ready, tick_ready, spike_valid, spike_idx
    );

    modport slave (
        input  evt_valid, evt_idx, tick, spike_ready,
        output evt_ready, tick_ready, spike_valid, spike_idx
    );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_array_update.sv
`default_nettype none
// ============================================================================
// Module      : lif_update
// Description : Combinational leak / threshold / refractory step for one neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_update
    import snn_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 20,
    parameter int LEAK       = 1,
    parameter int REFRACTORY = 2,
    parameter int RW         = 2
) (
    input  wire logic [WIDTH-1:0] i_pot,
    input  wire logic [RW-1:0]    i_refr,
    output logic      [WIDTH-1:0] o_pot,
    output logic      [RW-1:0]    o_refr,
    output logic                  o_fire
);
    localparam logic [c_MAX_W-1:0] c_THR  = THRESHOLD;
    localparam logic [c_MAX_W-1:0] c_LEAK = LEAK;
    localparam logic [RW-1:0]      c_REFR = RW'(REFRACTORY);

    logic [WIDTH-1:0] w_leaked;

    always_comb begin
        w_leaked = WIDTH'(sat_sub(c_MAX_W'(i_pot), c_LEAK));
        o_pot    = w_leaked;
        o_refr   = i_refr;
        o_fire   = 1'b0;
        // A refractory neuron is clamped to zero regardless of its stored value.
        if (i_refr != '0) begin
            o_pot  = '0;
            o_refr = i_refr - RW'(1);
        end else if (c_MAX_W'(w_leaked) > c_THR) begin
            o_pot  = '0;
            o_refr = c_REFR;
            o_fire = 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array
// Description : Array of LIF neurons with event integration and a tick sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int WIDTH       = 8,
    parameter int THRESHOLD   = 20,
    parameter int LEAK        = 1,
    parameter int REFRACTORY  = 2,
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    lif_neuron_array_if.slave     bus,
    input  wire logic             weight_w_en,
    input  wire logic [IDX_W-1:0] weight_idx,
    input  wire logic [WIDTH-1:0] weight_in,
    output logic                  sweep_done,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [WIDTH-1:0] rd_memb_pot
);
    localparam int               c_RW   = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_NEURONS - 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_spike_idx;
    logic [WIDTH-1:0] r_weight [NUM_NEURONS];
    logic [WIDTH-1:0] r_pot    [NUM_NEURONS];
    logic [c_RW-1:0]  r_refr   [NUM_NEURONS];
    logic [WIDTH-1:0] w_pot_upd;
    logic [c_RW-1:0]  w_refr_upd;
    logic             w_fire;

    lif_update #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .LEAK       (LEAK),
        .REFRACTORY (REFRACTORY),
        .RW         (c_RW)
    ) u_update (
        .i_pot  (r_pot[r_ptr]),
        .i_refr (r_refr[r_ptr]),
        .o_pot  (w_pot_upd),
        .o_refr (w_refr_upd),
        .o_fire (w_fire)
    );

    assign bus.spike_idx = r_spike_idx;
    assign rd_memb_pot   = r_pot[rd_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.evt_ready   = 1'b0;
        bus.tick_ready  = 1'b0;
        bus.spike_valid = 1'b0;
        sweep_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.evt_ready  = 1'b1;
                bus.tick_ready = 1'b1;
                if (bus.tick) w_next = S_SWEEP;
            end
            S_SWEEP: begin
                if (w_fire)               w_next = S_EMIT;
                else if (r_ptr == c_LAST) w_next = S_DONE;
            end
            S_EMIT: begin
                bus.spike_valid = 1'b1;
                if (bus.spike_ready) w_next = (r_ptr == c_LAST) ? S_DONE : S_SWEEP;
            end
            S_DONE: begin
                sweep_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Events read the pre-write weight, and a same-cycle tick sees the updated potential.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_weight[i] <= '0;
                r_pot[i]    <= '0;
                r_refr[i]   <= '0;
            end
            r_ptr       <= '0;
            r_spike_idx <= '0;
        end else begin
            if (weight_w_en) r_weight[weight_idx] <= weight_in;
            case (r_state)
                S_IDLE: begin
                    r_ptr <= '0;
                    if (bus.evt_valid && (r_refr[bus.evt_idx] == '0))
                        r_pot[bus.evt_idx] <= WIDTH'(sat_add(c_MAX_W'(r_pot[bus.evt_idx]),
                                                             c_MAX_W'(r_weight[bus.evt_idx]),
                                                             WIDTH));
                end
                S_SWEEP: begin
                    r_pot[r_ptr]  <= w_pot_upd;
                    r_refr[r_ptr] <= w_refr_upd;
                    if (w_fire)               r_spike_idx <= r_ptr;
                    else if (r_ptr != c_LAST) r_ptr       <= r_ptr + IDX_W'(1);
                end
                S_EMIT: begin
                    if (bus.spike_ready && (r_ptr != c_LAST)) r_ptr <= r_ptr + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
